// File: rtl/mul_pkg.sv
// mul_pkg: operand modes, FSM states and operand sign helper shared by iter_multiplier
package mul_pkg;
  localparam logic [1:0] MUL_UU = 2'b00;
  localparam logic [1:0] MUL_SS = 2'b01;
  localparam logic [1:0] MUL_SU = 2'b10;
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
  function automatic logic op_sign(input logic msb, input logic [1:0] mode, input logic is_y);
    return msb && mode != MUL_UU && (mode == MUL_SS || (mode == MUL_SU && !is_y));
  endfunction
endpackage

// File: rtl/mul_step_add.sv
// mul_step_add: parallel-prefix carry-lookahead sum s = a + b*d + cin over AW bits
module mul_step_add #(
  parameter int AW = 34,
  parameter int BW = 32,
  parameter int DW = 2
) (
  input  logic [AW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic [DW-1:0] d,
  input  logic          cin,
  output logic [AW-1:0] s
);
  logic [AW-1:0] pp, p, gg, pg, c;
  always_comb begin
    pp = AW'(b) * AW'(d);
    p = a ^ pp;
    gg = a & pp;
    pg = p;
    for (int k = 1; k < AW; k = k * 2)
      for (int i = AW - 1; i >= k; i--) begin
        gg[i] = gg[i] | (pg[i] & gg[i-k]);
        pg[i] = pg[i] & pg[i-k];
      end
    c = {gg[AW-2:0] | (pg[AW-2:0] & {(AW-1){cin}}), cin};
    s = p ^ c;
  end
endmodule

// File: rtl/iter_multiplier.sv
// iter_multiplier: multi-cycle UU/SS/SU multiplier retiring STEP bits per cycle behind valid/ready handshakes
module iter_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               busy
);
  localparam int CYC = WIDTH / STEP;
  localparam int CW = $clog2(CYC + 1);
  state_t state, state_n;
  logic [WIDTH-1:0] mcand, mplier;
  logic [2*WIDTH-1:0] acc, acc_neg;
  logic [WIDTH+STEP-1:0] sum;
  logic [CW-1:0] cnt;
  logic neg, sx, sy, accept;
  assign sx = op_sign(in_x[WIDTH-1], in_mode, 1'b0);
  assign sy = op_sign(in_y[WIDTH-1], in_mode, 1'b1);
  assign accept = state == IDLE && in_valid;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state == BUSY || state == DONE;
  mul_step_add #(.AW(WIDTH + STEP), .BW(WIDTH), .DW(STEP)) u_step (
    .a({{STEP{1'b0}}, acc[2*WIDTH-1:WIDTH]}),
    .b(mcand),
    .d(mplier[STEP-1:0]),
    .cin(1'b0),
    .s(sum)
  );
  mul_step_add #(.AW(2 * WIDTH), .BW(1), .DW(1)) u_neg (
    .a(~acc),
    .b(1'b0),
    .d(1'b0),
    .cin(1'b1),
    .s(acc_neg)
  );
  always_comb begin
    state_n = accept ? BUSY :
              (state == BUSY && cnt == CW'(1)) ? FIX :
              (state == FIX) ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      neg <= 1'b0;
      out_prod <= '0;
    end else if (accept) begin
      mcand <= sx ? -in_x : in_x;
      mplier <= sy ? -in_y : in_y;
      neg <= sx ^ sy;
      acc <= '0;
      cnt <= CW'(CYC);
    end else if (state == BUSY) begin
      acc <= {sum, acc[WIDTH-1:STEP]};
      mplier <= mplier >> STEP;
      cnt <= cnt - CW'(1);
    end else if (state == FIX) begin
      out_prod <= neg ? acc_neg : acc;
    end
  end
endmodule

// File: tb/tb_iter_multiplier.sv
// tb_iter_multiplier: scoreboard bench for directed cases on 32x2 plus a WIDTH/STEP sweep
module tb_iter_multiplier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv = 1'b0, orr = 1'b0;
  logic ir, ov, busy;
  logic [31:0] x = '0, y = '0;
  logic [1:0] m = '0;
  logic [63:0] prod;
  int nvec = 0, nerr = 0, sweeps_done = 0;
  logic sweep_go = 1'b0;
  logic [63:0] sb[$];
  always #5 clk = ~clk;
  iter_multiplier #(.WIDTH(32), .STEP(2)) dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_x(x), .in_y(y), .in_mode(m),
    .out_valid(ov), .out_ready(orr), .out_prod(prod), .busy(busy)
  );
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] md, input logic [63:0] e);
    int t = 0;
    x = a;
    y = b;
    m = md;
    iv = 1'b1;
    while (!ir && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    nvec++;
    if (ir !== 1'b1) begin
      nerr++;
      $display("FAIL send_ready: in_ready=%b required 1", ir);
    end
    sb.push_back(e);
    @(posedge clk); #1;
    iv = 1'b0;
  endtask
  task automatic wait_out(output int lat);
    lat = 0;
    while (ov !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask
  task automatic ack;
    orr = 1'b1;
    @(posedge clk); #1;
    orr = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    nvec++;
    if ({ir, ov, busy} !== 3'b100) begin
      nerr++;
      $display("FAIL reset_flags: {in_ready,out_valid,busy}=%b required 100", {ir, ov, busy});
    end
    nvec++;
    if (prod !== 64'h0) begin
      nerr++;
      $display("FAIL reset_prod: out_prod=%h required 0", prod);
    end
  endtask
  task automatic test_unsigned;
    int lat;
    logic [63:0] e;
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 64'hFFFFFFFE00000001);
    nvec++;
    if ({busy, ir} !== 2'b10) begin
      nerr++;
      $display("FAIL uu_busy: {busy,in_ready}=%b required 10", {busy, ir});
    end
    wait_out(lat);
    e = sb.pop_front();
    nvec++;
    if (lat != 17) begin
      nerr++;
      $display("FAIL uu_latency: got %0d required 17", lat);
    end
    nvec++;
    if (prod !== e) begin
      nerr++;
      $display("FAIL uu_prod: got %h required %h", prod, e);
    end
    ack;
  endtask
  task automatic test_signed;
    logic [31:0] xs[2], ys[2];
    logic [63:0] es[2];
    int lat;
    logic [63:0] e;
    xs = '{32'hFFFFFFFF, 32'h80000000};
    ys = '{32'hFFFFFFFF, 32'h80000000};
    es = '{64'h0000000000000001, 64'h4000000000000000};
    for (int i = 0; i < 2; i++) begin
      send(xs[i], ys[i], 2'b01, es[i]);
      wait_out(lat);
      e = sb.pop_front();
      nvec++;
      if (lat != 17) begin
        nerr++;
        $display("FAIL ss_latency[%0d]: got %0d required 17", i, lat);
      end
      nvec++;
      if (prod !== e) begin
        nerr++;
        $display("FAIL ss_prod[%0d]: got %h required %h", i, prod, e);
      end
      ack;
    end
  endtask
  task automatic test_mixed;
    logic [31:0] xs[3], ys[3];
    logic [1:0] ms[3];
    logic [63:0] es[3];
    int lat;
    logic [63:0] e;
    xs = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
    ys = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002};
    ms = '{2'b10, 2'b11, 2'b10};
    es = '{64'hFFFFFFFF00000001, 64'hFFFFFFFE00000001, 64'hFFFFFFFF00000000};
    for (int i = 0; i < 3; i++) begin
      send(xs[i], ys[i], ms[i], es[i]);
      wait_out(lat);
      e = sb.pop_front();
      nvec++;
      if (lat != 17) begin
        nerr++;
        $display("FAIL mixed_latency[%0d]: got %0d required 17", i, lat);
      end
      nvec++;
      if (prod !== e) begin
        nerr++;
        $display("FAIL mixed_prod[%0d]: got %h required %h", i, prod, e);
      end
      ack;
    end
  endtask
  task automatic test_backpressure;
    int lat;
    logic [63:0] e;
    send(32'd3, 32'd5, 2'b00, 64'd15);
    wait_out(lat);
    e = sb.pop_front();
    nvec++;
    if (lat != 17) begin
      nerr++;
      $display("FAIL bp_latency: got %0d required 17", lat);
    end
    for (int i = 0; i < 10; i++) begin
      nvec++;
      if (ov !== 1'b1 || ir !== 1'b0 || prod !== e) begin
        nerr++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b out_prod=%h required 1 0 %h", i, ov, ir, prod, e);
      end
      @(posedge clk); #1;
    end
    ack;
    nvec++;
    if (ir !== 1'b1 || ov !== 1'b0) begin
      nerr++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0", ir, ov);
    end
  endtask
  task automatic test_reset_mid;
    logic saw = 1'b0;
    send(32'd7, 32'd9, 2'b00, 64'd63);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb.pop_front());
    nvec++;
    if ({ir, ov, busy} !== 3'b100) begin
      nerr++;
      $display("FAIL abort_idle: {in_ready,out_valid,busy}=%b required 100", {ir, ov, busy});
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (ov === 1'b1) saw = 1'b1;
    end
    nvec++;
    if (saw !== 1'b0) begin
      nerr++;
      $display("FAIL abort_no_result: out_valid seen=%b required 0", saw);
    end
  endtask
  task automatic test_back_to_back;
    int lat;
    logic [63:0] e;
    send(32'h00010000, 32'h00010000, 2'b00, 64'h0000000100000000);
    x = 32'hFFFFFFFD;
    y = 32'd7;
    m = 2'b01;
    iv = 1'b1;
    orr = 1'b1;
    wait_out(lat);
    e = sb.pop_front();
    nvec++;
    if (lat != 17) begin
      nerr++;
      $display("FAIL b2b_latency_a: got %0d required 17", lat);
    end
    nvec++;
    if (prod !== e) begin
      nerr++;
      $display("FAIL b2b_prod_a: got %h required %h", prod, e);
    end
    @(posedge clk); #1;
    nvec++;
    if (ir !== 1'b1 || ov !== 1'b0) begin
      nerr++;
      $display("FAIL b2b_idle: in_ready=%b out_valid=%b required 1 0", ir, ov);
    end
    sb.push_back(64'hFFFFFFFFFFFFFFEB);
    @(posedge clk); #1;
    iv = 1'b0;
    orr = 1'b0;
    wait_out(lat);
    e = sb.pop_front();
    nvec++;
    if (lat != 17) begin
      nerr++;
      $display("FAIL b2b_latency_b: got %0d required 17", lat);
    end
    nvec++;
    if (prod !== e) begin
      nerr++;
      $display("FAIL b2b_prod_b: got %h required %h", prod, e);
    end
    ack;
  endtask
  task automatic test_sweep;
    int cyc = 0;
    sweep_go = 1'b1;
    while (sweeps_done < 6 && cyc < 70000) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    nvec++;
    if (sweeps_done != 6) begin
      nerr++;
      $display("FAIL sweep_timeout: configs finished %0d required 6", sweeps_done);
    end
  endtask
  for (genvar g = 0; g < 6; g++) begin : sw
    localparam int W = (g < 3) ? 8 : 32;
    localparam int S = 1 << (g % 3);
    localparam int LAT = W / S + 1;
    logic s_iv = 1'b0, s_orr = 1'b1;
    logic s_ir, s_ov, s_busy;
    logic [W-1:0] s_x = '0, s_y = '0;
    logic [1:0] s_m = '0;
    logic [2*W-1:0] s_p;
    logic [2*W-1:0] q[$];
    iter_multiplier #(.WIDTH(W), .STEP(S)) u (
      .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(s_ir), .in_x(s_x), .in_y(s_y), .in_mode(s_m),
      .out_valid(s_ov), .out_ready(s_orr), .out_prod(s_p), .busy(s_busy)
    );
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] md);
      logic [2*W-1:0] ae, be;
      ae = (md == 2'b01 || md == 2'b10) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
      be = (md == 2'b01) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
      return ae * be;
    endfunction
    initial begin
      logic [W-1:0] cor[5];
      logic [2*W-1:0] e;
      int lat;
      cor[0] = '0;
      cor[1] = W'(1);
      cor[2] = '1;
      cor[3] = {1'b1, {(W-1){1'b0}}};
      cor[4] = {1'b0, {(W-1){1'b1}}};
      wait (sweep_go);
      @(posedge clk); #1;
      for (int n = 0; n < 1100; n++) begin
        if (n < 100) begin
          s_x = cor[n % 5];
          s_y = cor[(n / 5) % 5];
          s_m = 2'(n / 25);
        end else begin
          s_x = W'($urandom);
          s_y = W'($urandom);
          s_m = 2'($urandom_range(0, 3));
        end
        s_iv = 1'b1;
        q.push_back(model(s_x, s_y, s_m));
        @(posedge clk); #1;
        s_iv = 1'b0;
        lat = 0;
        while (s_ov !== 1'b1 && lat < 200) begin
          @(posedge clk); #1;
          lat++;
        end
        e = q.pop_front();
        nvec++;
        if (lat != LAT) begin
          nerr++;
          $display("FAIL sweep_latency W%0d S%0d: got %0d required %0d", W, S, lat, LAT);
        end
        nvec++;
        if (s_p !== e) begin
          nerr++;
          $display("FAIL sweep_prod W%0d S%0d x=%h y=%h m=%0d: got %h required %h", W, S, s_x, s_y, s_m, s_p, e);
        end
        @(posedge clk); #1;
      end
      sweeps_done++;
    end
  end
  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_mixed;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    test_sweep;
    nvec++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
